store_unit: RTL and testbench
=============================

# store_unit

Parametrised store path between the execute stage and the data-memory port. Accepts one store request per handshake and decodes funct3 into size. Computes byte enables and lane-aligned write data, then issues one memory beat, or two when the access straddles a word boundary. Reports completion or a fault to the pipeline control.

## Interface
Parameters:
- XLEN, 32, data width; 32 or 64 (64 enables sd).
- ADDR_W, 32, byte-address width.
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing stores into two beats; 0 = fault.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_data  in  XLEN  store data, LSB-justified.
- req_funct3  in  3  000 sb, 001 sh, 010 sw, 011 sd (XLEN=64 only).
- mem_valid  out  1  memory beat present.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero).
- mem_wdata  out  XLEN  lane-aligned data; disabled lanes zero.
- mem_be  out  XLEN/8  byte enables.
- done  out  1  one-cycle pulse: store fully written.
- fault  out  1  one-cycle pulse: request rejected, no memory traffic.
- fault_cause  out  2  01 misaligned (ALLOW_MISALIGNED=0), 10 illegal funct3; valid with fault, else 00.

## Operation
- NB = XLEN/8; off = req_addr[log2(NB)-1:0]; size = 1 << funct3[1:0].
- Illegal funct3: funct3[2]=1, or funct3[1:0]=11 with XLEN=32. Illegal takes priority over misaligned.
- Mask: 2*NB-bit mask ((1<<size)-1) << off. Data: {XLEN'0, req_data[size*8-1:0]} << (off*8) in 2*XLEN bits. The low half forms beat 0 and the high half forms beat 1.
- Split when the high mask half is nonzero. Beat 1 address = aligned address + NB, wrapping modulo 2^ADDR_W.
- States: IDLE, BEAT0, BEAT1. Mask, data and beat-1 address are registered on accept.
- IDLE: on req_valid & req_ready:
  - illegal, or split with ALLOW_MISALIGNED=0: fault pulse next cycle; stay IDLE.
  - otherwise go to BEAT0.
- BEAT0: mem_valid=1. On mem_ready, go to BEAT1 if split; otherwise go to IDLE and pulse done.
- BEAT1: mem_valid=1. On mem_ready, go to IDLE and pulse done.
- Exactly one done or one fault per accepted request, never both.

## Timing
- Reset values (cycle after rst high): state IDLE, req_ready=1, mem_valid=0, mem_addr/mem_wdata/mem_be=0, done=0, fault=0, fault_cause=00.
- Accept at edge t: mem_valid high from t+1. With mem_ready=1:
  - single beat: done high in cycle t+2.
  - split: beat 1 in cycle t+2, done in cycle t+3.
- Fault: accept at t, fault high in cycle t+1 only.
- While mem_valid=1 and mem_ready=0, mem_addr/mem_wdata/mem_be are held stable; mem_valid never drops without a handshake.
- done is asserted in IDLE, so req_ready=1 in the same cycle and back-to-back accepts are legal. Peak throughput: one aligned store per 2 cycles.
- rst during BEAT0/BEAT1 abandons the store: mem_valid=0 next cycle, no done, any remaining beat is dropped.
- req_* inputs are ignored outside IDLE.

## Structure
- Shared package store_pkg holds:
  - funct3 constants F3_SB/F3_SH/F3_SW/F3_SD;
  - fault-cause codes CAUSE_NONE/CAUSE_MISALIGN/CAUSE_ILLEGAL;
  - state enum {IDLE, BEAT0, BEAT1}.
- One combinational sub-module, store_align: takes XLEN, offset, funct3 and data. It returns the 2*NB mask, the 2*XLEN shifted data, the split flag and the illegal flag. The FSM and registers live in store_unit.

## Test plan
- XLEN=32, sw addr 0x1000 data 0xDEADBEEF, mem_ready=1 -> cycle t+1: mem_addr 0x1000, be 1111, wdata 0xDEADBEEF; done at t+2.
- sb addr 0x1003 data 0x000000A5 -> single beat: addr 0x1000, be 1000, wdata 0xA5000000; done once.
- ALLOW_MISALIGNED=1, sh addr 0x1003 data 0x1234 -> beat0: addr 0x1000, be 1000, wdata 0x34000000. Beat1: addr 0x1004, be 0001, wdata 0x00000012. One done.
- sw addr 0xFFFFFFFE data 0xAABBCCDD -> beat0: addr 0xFFFFFFFC, be 1100, wdata 0xCCDD0000. Beat1: addr 0x00000000, be 0011, wdata 0x0000AABB.
- ALLOW_MISALIGNED=0, sh addr 0x1003 -> mem_valid stays 0; fault at t+1 with cause 01. XLEN=32 funct3=011 or funct3=100 -> fault with cause 10.
- sw accepted, mem_ready=0 for 3 cycles -> outputs stable. Then rst=1 -> mem_valid=0 next cycle, no done, req_ready=1.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: constants and types shared by the store path.
//   F3_*     : funct3 encodings of the store sizes (sb/sh/sw/sd).
//   CAUSE_*  : fault_cause codes reported alongside a fault pulse.
//   state_e  : store_unit FSM states.
package store_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;
   localparam logic [2:0] F3_SD = 3'b011;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_e;

endpackage

// File: rtl/store_align.sv
// store_align: combinational lane alignment for one store request.
//   off     in  byte offset within the data word
//   funct3  in  store size encoding
//   data    in  LSB-justified store data
//   mask    out 2*NB byte enables; low half = beat 0, high half = beat 1
//   sdata   out 2*XLEN lane-shifted data; low half = beat 0, high half = beat 1
//   split   out access touches the following word
//   illegal out funct3 does not name a store this XLEN supports
module store_align
   import store_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [$clog2(XLEN/8)-1:0] off,
   input  logic [2:0]                funct3,
   input  logic [XLEN-1:0]           data,
   output logic [2*(XLEN/8)-1:0]     mask,
   output logic [2*XLEN-1:0]         sdata,
   output logic                      split,
   output logic                      illegal
);

   localparam int NB = XLEN / 8;

   int              size;
   logic [XLEN-1:0] trimmed;

   // NOTE: every output of this block is given a value on every path before
   // any conditional update, so no latch can be inferred.
   always_comb begin
      size    = 1 << funct3[1:0];
      illegal = funct3[2] | ((XLEN == 32) && (funct3 == F3_SD));

      // Bytes above the access size must not leak into enabled-off lanes.
      trimmed = '0;
      for (int b = 0; b < NB; b++) begin
         if (b < size) trimmed[b*8 +: 8] = data[b*8 +: 8];
      end

      mask = '0;
      for (int i = 0; i < 2*NB; i++) begin
         mask[i] = (i >= int'(off)) && (i < int'(off) + size);
      end

      sdata = {{XLEN{1'b0}}, trimmed} << {off, 3'b000};
      split = |mask[2*NB-1:NB];
   end

endmodule

// File: rtl/store_unit.sv
// store_unit: store path from execute stage to the data-memory port.
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while IDLE
//   req_addr/data/funct3 byte address, LSB-justified data, size encoding
//   mem_valid/mem_ready  memory beat handshake
//   mem_addr/wdata/be    word-aligned address, lane-aligned data, byte enables
//   done                 one-cycle pulse when the store is fully written
//   fault, fault_cause   one-cycle pulse and reason when a request is rejected
module store_unit
   import store_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter int ADDR_W           = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_data,
   input  logic [2:0]          req_funct3,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   output logic                done,
   output logic                fault,
   output logic [1:0]          fault_cause
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   logic [2*NB-1:0]   al_mask;
   logic [2*XLEN-1:0] al_data;
   logic              al_split;
   logic              al_illegal;
   logic [ADDR_W-1:0] aligned_addr;

   store_align #(.XLEN(XLEN)) u_align (
      .off     (req_addr[OFF_W-1:0]),
      .funct3  (req_funct3),
      .data    (req_data),
      .mask    (al_mask),
      .sdata   (al_data),
      .split   (al_split),
      .illegal (al_illegal)
   );

   assign aligned_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   state_e            state_q,     state_d;
   logic              mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]     mem_be_q,    mem_be_d;
   logic              done_q,      done_d;
   logic              fault_q,     fault_d;
   logic [1:0]        cause_q,     cause_d;
   // Beat-1 payload captured on accept; the beat-0 payload lives directly
   // in the mem_* output registers.
   logic              split_q,     split_d;
   logic [ADDR_W-1:0] addr1_q,     addr1_d;
   logic [XLEN-1:0]   hi_data_q,   hi_data_d;
   logic [NB-1:0]     hi_be_q,     hi_be_d;

   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      split_d     = split_q;
      addr1_d     = addr1_q;
      hi_data_d   = hi_data_q;
      hi_be_d     = hi_be_q;
      done_d      = 1'b0;
      fault_d     = 1'b0;
      cause_d     = CAUSE_NONE;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (al_illegal) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_ILLEGAL;
               end else if (al_split && (ALLOW_MISALIGNED == 0)) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_MISALIGN;
               end else begin
                  state_d     = BEAT0;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = aligned_addr;
                  mem_wdata_d = al_data[XLEN-1:0];
                  mem_be_d    = al_mask[NB-1:0];
                  split_d     = al_split;
                  addr1_d     = aligned_addr + ADDR_W'(NB);  // wraps at 2^ADDR_W
                  hi_data_d   = al_data[2*XLEN-1:XLEN];
                  hi_be_d     = al_mask[2*NB-1:NB];
               end
            end
         end
         BEAT0: begin
            if (mem_ready) begin
               if (split_q) begin
                  state_d     = BEAT1;
                  mem_addr_d  = addr1_q;
                  mem_wdata_d = hi_data_q;
                  mem_be_d    = hi_be_q;
               end else begin
                  state_d     = IDLE;
                  mem_valid_d = 1'b0;
                  done_d      = 1'b1;
               end
            end
         end
         BEAT1: begin
            if (mem_ready) begin
               state_d     = IDLE;
               mem_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         cause_q     <= CAUSE_NONE;
         split_q     <= 1'b0;
         addr1_q     <= '0;
         hi_data_q   <= '0;
         hi_be_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
         cause_q     <= cause_d;
         split_q     <= split_d;
         addr1_q     <= addr1_d;
         hi_data_q   <= hi_data_d;
         hi_be_q     <= hi_be_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign mem_valid   = mem_valid_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign done        = done_q;
   assign fault       = fault_q;
   assign fault_cause = cause_q;

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and randomized checks of store_unit (XLEN=32).
// Instance 0 has ALLOW_MISALIGNED=0, instance 1 has ALLOW_MISALIGNED=1;
// they share address/data/funct3/mem_ready and have separate req_valid.
// Expected beats come from a byte-by-byte model: each written byte lands at
// address addr+k, and bytes are grouped by the word they fall into.
module tb_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_v [2];
   logic        req_ready_v [2];
   logic [31:0] req_addr   = '0;
   logic [31:0] req_data   = '0;
   logic [2:0]  req_funct3 = '0;
   logic        mem_ready  = 1'b0;
   logic        mem_valid_v [2];
   logic [31:0] mem_addr_v  [2];
   logic [31:0] mem_wdata_v [2];
   logic [3:0]  mem_be_v    [2];
   logic        done_v      [2];
   logic        fault_v     [2];
   logic [1:0]  cause_v     [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
      .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
      .mem_valid(mem_valid_v[0]), .mem_ready(mem_ready),
      .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]), .mem_be(mem_be_v[0]),
      .done(done_v[0]), .fault(fault_v[0]), .fault_cause(cause_v[0])
   );

   store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
      .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
      .mem_valid(mem_valid_v[1]), .mem_ready(mem_ready),
      .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]), .mem_be(mem_be_v[1]),
      .done(done_v[1]), .fault(fault_v[1]), .fault_cause(cause_v[1])
   );

   // Reference model results
   int          exp_nb;
   logic [1:0]  exp_cause;
   logic [31:0] exp_addr [2];
   logic [3:0]  exp_be   [2];
   logic [31:0] exp_data [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] f3, input bit allow);
      int          size;
      logic [31:0] a;
      logic [31:0] w;
      exp_nb    = 0;
      exp_cause = 2'b00;
      for (int i = 0; i < 2; i++) begin
         exp_addr[i] = '0;
         exp_be[i]   = '0;
         exp_data[i] = '0;
      end
      if (f3[2] || f3[1:0] == 2'b11) begin
         exp_cause = 2'b10;
         return;
      end
      size = 1 << f3[1:0];
      for (int k = 0; k < size; k++) begin
         a = addr + 32'(k);
         w = {a[31:2], 2'b00};
         if (exp_nb == 0 || exp_addr[exp_nb-1] != w) begin
            exp_addr[exp_nb] = w;
            exp_nb++;
         end
         exp_be[exp_nb-1][a[1:0]]            = 1'b1;
         exp_data[exp_nb-1][a[1:0]*8 +: 8]   = data[k*8 +: 8];
      end
      if (exp_nb > 1 && !allow) begin
         exp_cause = 2'b01;
         exp_nb    = 0;
      end
   endtask

   // Called at a negedge with the chosen instance idle; returns at the
   // negedge of the cycle in which done/fault is expected, after checking it.
   task automatic run(input int u, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] f3, input int stall_max);
      int stall;
      model(addr, data, f3, (u == 1));
      check("req_ready_before", req_ready_v[u], 1'b1);
      req_valid_v[u] = 1'b1;
      req_addr       = addr;
      req_data       = data;
      req_funct3     = f3;
      @(posedge clk);
      @(negedge clk);
      req_valid_v[u] = 1'b0;
      if (exp_cause != 2'b00) begin
         check("fault_pulse", fault_v[u], 1'b1);
         check("fault_cause", cause_v[u], exp_cause);
         check("fault_no_mem", mem_valid_v[u], 1'b0);
         check("fault_no_done", done_v[u], 1'b0);
         check("fault_ready", req_ready_v[u], 1'b1);
         return;
      end
      for (int b = 0; b < exp_nb; b++) begin
         stall = $urandom_range(0, stall_max);
         for (int s = 0; s <= stall; s++) begin
            check("beat_valid", mem_valid_v[u], 1'b1);
            check("beat_addr",  mem_addr_v[u],  exp_addr[b]);
            check("beat_be",    mem_be_v[u],    exp_be[b]);
            check("beat_wdata", mem_wdata_v[u], exp_data[b]);
            check("beat_no_done",  done_v[u],  1'b0);
            check("beat_no_fault", fault_v[u], 1'b0);
            check("beat_cause",    cause_v[u], 2'b00);
            check("beat_not_ready", req_ready_v[u], 1'b0);
            mem_ready = (s == stall);
            @(negedge clk);
         end
      end
      mem_ready = 1'b0;
      check("done_pulse", done_v[u], 1'b1);
      check("done_no_mem", mem_valid_v[u], 1'b0);
      check("done_ready", req_ready_v[u], 1'b1);
      check("done_no_fault", fault_v[u], 1'b0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [2:0]  rf;
      int          r;

      req_valid_v[0] = 1'b0;
      req_valid_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         check("rst_ready", req_ready_v[u], 1'b1);
         check("rst_valid", mem_valid_v[u], 1'b0);
         check("rst_addr",  mem_addr_v[u],  32'h0);
         check("rst_wdata", mem_wdata_v[u], 32'h0);
         check("rst_be",    mem_be_v[u],    4'h0);
         check("rst_done",  done_v[u],      1'b0);
         check("rst_fault", fault_v[u],     1'b0);
         check("rst_cause", cause_v[u],     2'b00);
      end

      // Directed cases
      run(1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b010, 0);
      run(1, 32'h0000_1003, 32'h0000_00A5, 3'b000, 0);
      run(1, 32'h0000_1003, 32'h0000_1234, 3'b001, 0);
      run(1, 32'hFFFF_FFFE, 32'hAABB_CCDD, 3'b010, 0);
      run(0, 32'h0000_1003, 32'h0000_1234, 3'b001, 0);
      run(0, 32'h0000_1000, 32'h1111_1111, 3'b011, 0);
      run(0, 32'h0000_1003, 32'h2222_2222, 3'b100, 0);
      run(0, 32'h0000_1002, 32'h0000_5678, 3'b001, 0);
      run(1, 32'h0000_1001, 32'h7766_5544, 3'b010, 2);

      // Randomized stores with random memory back-pressure
      for (int i = 0; i < 60; i++) begin
         r  = $urandom_range(0, 9);
         rf = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010
                                                 : 3'($urandom_range(3, 7));
         ra = $urandom;
         if ($urandom_range(0, 5) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         run((i % 4 == 0) ? 0 : 1, ra, $urandom, rf, 3);
      end

      // Stalled store abandoned by reset; request inputs toggled meanwhile
      // must be ignored.
      @(negedge clk);
      mem_ready      = 1'b0;
      req_valid_v[1] = 1'b1;
      req_addr       = 32'h0000_2000;
      req_data       = 32'h1122_3344;
      req_funct3     = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'h0000_3005;
      req_data = 32'h0;
      for (int s = 0; s < 4; s++) begin
         check("stall_valid", mem_valid_v[1], 1'b1);
         check("stall_addr",  mem_addr_v[1],  32'h0000_2000);
         check("stall_be",    mem_be_v[1],    4'hF);
         check("stall_wdata", mem_wdata_v[1], 32'h1122_3344);
         check("stall_no_done", done_v[1], 1'b0);
         @(negedge clk);
      end
      rst            = 1'b1;
      req_valid_v[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("abort_valid", mem_valid_v[1], 1'b0);
      check("abort_done",  done_v[1],      1'b0);
      check("abort_ready", req_ready_v[1], 1'b1);
      check("abort_addr",  mem_addr_v[1],  32'h0);
      mem_ready = 1'b1;
      @(negedge clk);
      check("abort_no_done_late", done_v[1], 1'b0);
      check("abort_still_idle",   mem_valid_v[1], 1'b0);
      mem_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
